// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and widths for the two-pass ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int W_HALF = 16;
  localparam int W_OP   = 2 * W_HALF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [W_OP-1:0] a;
    logic [W_OP-1:0] b;
    logic [3:0]      select;
    logic            mode;
    logic            carry_in;
    logic            id;
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-requester round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  import alu_seq_pkg::*;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    o_grant_id = 1'b0;
    case (i_req)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = 1'b0;
    endcase
    if (i_req == 2'b00) begin
      o_grant = 2'b00;
    end else begin
      o_grant = o_grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Arbitrates two 32-bit op requesters and runs each op as two
//               chained 16-bit passes through an external combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
  parameter int W_HALF = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_req_valid,
  output logic [1:0]              o_req_ready,
  input  logic [4*W_HALF-1:0]     i_req_a,
  input  logic [4*W_HALF-1:0]     i_req_b,
  input  logic [7:0]              i_req_select,
  input  logic [1:0]              i_req_mode,
  input  logic [1:0]              i_req_carry_in,
  output logic [W_HALF-1:0]       o_alu_in_a,
  output logic [W_HALF-1:0]       o_alu_in_b,
  output logic [3:0]              o_alu_select,
  output logic                    o_alu_mode,
  output logic                    o_alu_carry_in,
  input  logic [W_HALF-1:0]       i_alu_out,
  input  logic                    i_alu_carry_out,
  input  logic                    i_alu_compare,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [2*W_HALF-1:0]     o_resp_data,
  output logic                    o_resp_carry,
  output logic                    o_resp_compare,
  output logic                    o_resp_id
);

  import alu_seq_pkg::*;

  localparam int W_DATA = 2 * W_HALF;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LO   = LO;
  localparam logic [1:0] S_HI   = HI;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        r_state;
  alu_op_t           r_op;
  logic              r_last_grant;
  logic [W_HALF-1:0] r_res_lo;
  logic              r_carry_mid;
  logic              r_resp_valid;
  logic [W_DATA-1:0] r_resp_data;
  logic              r_resp_carry;
  logic              r_resp_compare;
  logic              r_resp_id;

  logic [1:0]        w_grant;
  logic              w_gid;
  alu_op_t           w_new_op;

  rr_arbiter2 u_arb (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_gid)
  );

  always_comb begin
    w_new_op.a        = w_gid ? i_req_a[2*W_DATA-1:W_DATA] : i_req_a[W_DATA-1:0];
    w_new_op.b        = w_gid ? i_req_b[2*W_DATA-1:W_DATA] : i_req_b[W_DATA-1:0];
    w_new_op.select   = w_gid ? i_req_select[7:4] : i_req_select[3:0];
    w_new_op.mode     = i_req_mode[w_gid];
    w_new_op.carry_in = i_req_carry_in[w_gid];
    w_new_op.id       = w_gid;
  end

  // Gated with rst so no accept strobe leaks out while reset is held.
  assign o_req_ready = (r_state == S_IDLE && !rst) ? w_grant : 2'b00;

  always_comb begin
    o_alu_in_a     = '0;
    o_alu_in_b     = '0;
    o_alu_select   = 4'd0;
    o_alu_mode     = 1'b0;
    o_alu_carry_in = 1'b0;
    case (r_state)
      S_LO: begin
        o_alu_in_a     = r_op.a[W_HALF-1:0];
        o_alu_in_b     = r_op.b[W_HALF-1:0];
        o_alu_select   = r_op.select;
        o_alu_mode     = r_op.mode;
        o_alu_carry_in = ~r_op.mode & r_op.carry_in;
      end
      S_HI: begin
        o_alu_in_a     = r_op.a[W_DATA-1:W_HALF];
        o_alu_in_b     = r_op.b[W_DATA-1:W_HALF];
        o_alu_select   = r_op.select;
        o_alu_mode     = r_op.mode;
        o_alu_carry_in = ~r_op.mode & r_carry_mid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_last_grant   <= 1'b1;
      r_res_lo       <= '0;
      r_carry_mid    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= '0;
      r_resp_carry   <= 1'b0;
      r_resp_compare <= 1'b0;
      r_resp_id      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_op         <= w_new_op;
            r_last_grant <= w_gid;
            r_state      <= S_LO;
          end
        end
        S_LO: begin
          r_res_lo    <= i_alu_out;
          r_carry_mid <= i_alu_carry_out;
          r_state     <= S_HI;
        end
        S_HI: begin
          // Flags are meaningless for logic ops, so they are suppressed.
          r_resp_data    <= {i_alu_out, r_res_lo};
          r_resp_carry   <= ~r_op.mode & i_alu_carry_out;
          r_resp_compare <= ~r_op.mode & i_alu_compare;
          r_resp_id      <= r_op.id;
          r_resp_valid   <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_resp_valid   = r_resp_valid;
  assign o_resp_data    = r_resp_data;
  assign o_resp_carry   = r_resp_carry;
  assign o_resp_compare = r_resp_compare;
  assign o_resp_id      = r_resp_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed self-checking bench for alu_seq_ctrl with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_select;
  logic [1:0]  req_mode;
  logic [1:0]  req_carry_in;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_co;
  logic        alu_cmp;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_carry;
  logic        resp_compare;
  logic        resp_id;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  logic busy = 1'b0;

  alu_seq_ctrl #(.W_HALF(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_select   (req_select),
    .i_req_mode     (req_mode),
    .i_req_carry_in (req_carry_in),
    .o_alu_in_a     (alu_in_a),
    .o_alu_in_b     (alu_in_b),
    .o_alu_select   (alu_select),
    .o_alu_mode     (alu_mode),
    .o_alu_carry_in (alu_cin),
    .i_alu_out      (alu_out),
    .i_alu_carry_out(alu_co),
    .i_alu_compare  (alu_cmp),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_data    (resp_data),
    .o_resp_carry   (resp_carry),
    .o_resp_compare (resp_compare),
    .o_resp_id      (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: arith sel 0 = a+b+cin, sel 1 = a+~b+cin; logic mode drives flags high.
  always_comb begin
    alu_out = 16'd0;
    alu_co  = 1'b0;
    alu_cmp = 1'b0;
    if (!alu_mode) begin
      if (alu_select == 4'd1)
        {alu_co, alu_out} = {1'b0, alu_in_a} + {1'b0, ~alu_in_b} + 17'(alu_cin);
      else
        {alu_co, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + 17'(alu_cin);
      alu_cmp = (alu_in_a == alu_in_b);
    end else begin
      case (alu_select)
        4'd0:    alu_out = alu_in_a & alu_in_b;
        4'd1:    alu_out = alu_in_a | alu_in_b;
        4'd2:    alu_out = alu_in_a ^ alu_in_b;
        default: alu_out = ~alu_in_a;
      endcase
      alu_co  = 1'b1;
      alu_cmp = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (busy && req_ready != 2'b00) viol++;
      if (req_ready != 2'b00) busy = 1'b1;
      if (resp_valid && resp_ready) busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic mode, input logic cin);
    req_a[id*32 +: 32]    = a;
    req_b[id*32 +: 32]    = b;
    req_select[id*4 +: 4] = sel;
    req_mode[id]          = mode;
    req_carry_in[id]      = cin;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'(n), 64'(0));
  endtask

  // Single-requester op; starts and ends in IDLE at posedge+2.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic mode, input logic cin,
                        input logic [31:0] exp_data, input logic exp_c, input logic exp_cmp,
                        input logic exp_lo_cin, input logic exp_hi_cin);
    set_req(id, a, b, sel, mode, cin);
    req_valid[id] = 1'b1;
    resp_ready    = 1'b0;
    #1;
    wait_ready();
    check("accept_onehot", 64'(req_ready), 64'(id == 1 ? 2'b10 : 2'b01));
    tick();
    req_valid[id] = 1'b0;
    check("lo_a", 64'(alu_in_a), 64'(a[15:0]));
    check("lo_b", 64'(alu_in_b), 64'(b[15:0]));
    check("lo_sel", 64'({alu_select, alu_mode}), 64'({sel, mode}));
    check("lo_cin", 64'(alu_cin), 64'(exp_lo_cin));
    check("lo_ready", 64'(req_ready), 64'(0));
    tick();
    check("hi_a", 64'(alu_in_a), 64'(a[31:16]));
    check("hi_b", 64'(alu_in_b), 64'(b[31:16]));
    check("hi_cin", 64'(alu_cin), 64'(exp_hi_cin));
    check("hi_no_valid", 64'(resp_valid), 64'(0));
    tick();
    check("done_valid", 64'(resp_valid), 64'(1));
    check("done_data", 64'(resp_data), 64'(exp_data));
    check("done_carry", 64'(resp_carry), 64'(exp_c));
    check("done_cmp", 64'(resp_compare), 64'(exp_cmp));
    check("done_id", 64'(resp_id), 64'(id));
    check("done_alu_idle", 64'({alu_in_a, alu_in_b, alu_cin}), 64'(0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("drop_valid", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] rr_data [2];
    int n;
    rst          = 1'b1;
    req_valid    = 2'b00;
    req_a        = '0;
    req_b        = '0;
    req_select   = '0;
    req_mode     = '0;
    req_carry_in = '0;
    resp_ready   = 1'b0;
    #2;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_resp", 64'({resp_valid, resp_data, resp_carry, resp_compare, resp_id}), 64'(0));
    check("rst_alu", 64'({alu_in_a, alu_in_b, alu_select, alu_mode, alu_cin}), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // add with carry chained from low into high pass
    run_op(0, 32'h0000_FFFF, 32'h0000_0001, 4'd0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1, 32'h0005_0000, 32'h0001_0003, 4'd1, 1'b0, 1'b1, 32'h0003_FFFD, 1'b1, 1'b0, 1'b1, 1'b0);

    // both requesters held valid: grants alternate
    set_req(0, 32'h1234_5678, 32'h1111_1111, 4'd0, 1'b0, 1'b0);
    set_req(1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2, 1'b1, 1'b0);
    rr_data[0] = 32'h2345_6789;
    rr_data[1] = 32'hF00F_F00F;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      check("rr_grant", 64'(req_ready), 64'((k % 2) == 1 ? 2'b10 : 2'b01));
      n = 0;
      tick();
      while (!resp_valid && n < 20) begin
        tick();
        n++;
      end
      check("rr_latency", 64'(n), 64'(2));
      check("rr_data", 64'(resp_data), 64'(rr_data[k % 2]));
      check("rr_id", 64'(resp_id), 64'(k % 2));
      check("rr_flags", 64'({resp_carry, resp_compare}), 64'(0));
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    tick();

    // back-pressure: response held while consumer stalls
    set_req(1, 32'h0000_0001, 32'h0000_0002, 4'd0, 1'b0, 1'b0);
    req_valid = 2'b10;
    #1;
    wait_ready();
    check("hold_accept", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b11;
    tick();
    tick();
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_data", 64'(resp_data), 64'(32'h0000_0003));
      check("hold_no_ready", 64'(req_ready), 64'(0));
      if (i < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    check("hold_drop", 64'(resp_valid), 64'(0));
    check("hold_next_accept", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check("hold_data_kept", 64'(resp_data), 64'(32'h0000_0003));
    tick();
    tick();
    check("hold_next_data", 64'(resp_data), 64'(32'h2345_6789));
    check("hold_next_id", 64'(resp_id), 64'(0));
    tick();
    resp_ready = 1'b0;

    // asynchronous reset during the high pass
    set_req(0, 32'h0000_0010, 32'h0000_0020, 4'd0, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    wait_ready();
    tick();
    tick();
    check("pre_rst_hi", 64'(alu_in_a), 64'(16'h0000));
    check("pre_rst_hi_b", 64'(alu_in_b), 64'(16'h0000));
    req_valid = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    check("arst_ready", 64'(req_ready), 64'(0));
    check("arst_alu", 64'({alu_in_a, alu_in_b, alu_select, alu_mode, alu_cin}), 64'(0));
    check("arst_resp", 64'({resp_valid, resp_data, resp_carry, resp_compare, resp_id}), 64'(0));
    tick();
    check("arst_no_resp", 64'(resp_valid), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check("post_rst_lo_valid", 64'(resp_valid), 64'(0));
    tick();
    tick();
    check("post_rst_valid", 64'(resp_valid), 64'(1));
    check("post_rst_data", 64'(resp_data), 64'(32'h0000_0030));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();

    check("ready_outside_idle", 64'(viol), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
